// File: rtl/gpio_poll_master.sv
// GPIO poll master: writes the GPIO ctrl register once per enable, then periodically
// reads the data register and raises a sticky per-bit change interrupt. Optional: GPIO_POLL_DEBOUNCE_EN.
module gpio_poll_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] POLL_DIV  = 16'd1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en_i,
  input  logic [31:0] ctrl_i,
  input  logic [31:0] mask_i,
  input  logic        irq_clr_i,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic [31:0] snap_o,
  output logic [31:0] chg_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {IDLE, CFG, WAIT, RD, CMP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [31:0] sample;
  logic        first;
  logic [31:0] accepted;
  logic [31:0] diff;

  // Bus outputs decode straight from the state register, so an asynchronous reset
  // drops req_o at once and an abandoned request disappears with the state change.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    state_nxt = state;
    req_o     = 1'b0;
    we_o      = 1'b0;
    addr_o    = 32'h0;
    data_o    = 32'h0;
    unique case (state)
      IDLE: if (en_i) state_nxt = CFG;
      CFG: begin
        req_o  = 1'b1;
        we_o   = 1'b1;
        addr_o = BASE_ADDR;
        data_o = ctrl_i;
        if (gnt_i) state_nxt = WAIT;
      end
      WAIT: if (cnt == 16'd0) state_nxt = RD;
      RD: begin
        req_o  = 1'b1;
        addr_o = BASE_ADDR + 32'd4;
        if (gnt_i) state_nxt = CMP;
      end
      CMP:     state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
    // Disable wins over everything; a grant in this cycle still completes on the bus.
    if (!en_i) state_nxt = IDLE;
  end

`ifdef GPIO_POLL_DEBOUNCE_EN
  logic [31:0] prev_raw;
  logic [31:0] agree;

  // A bit is taken only when this read and the previous raw read agree on it.
  assign agree    = ~(sample ^ prev_raw);
  assign accepted = first ? sample : ((sample & agree) | (snap_o & ~agree));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              prev_raw <= 32'h0;
    else if (state == CMP)  prev_raw <= sample;
  end
`else
  assign accepted = sample;
`endif

  assign diff  = first ? 32'h0 : ((accepted ^ snap_o) & mask_i);
  assign irq_o = |chg_o;

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= 16'h0;
      sample <= 32'h0;
      snap_o <= 32'h0;
      chg_o  <= 32'h0;
      first  <= 1'b0;
    end else begin
      state <= state_nxt;

      if ((state == CFG && gnt_i) || state == CMP)
        cnt <= POLL_DIV - 16'd1;
      else if (state == WAIT && cnt != 16'd0)
        cnt <= cnt - 16'd1;

      if (state == CFG && gnt_i) first <= 1'b1;
      else if (state == CMP)     first <= 1'b0;

      if (state == RD && gnt_i) sample <= data_i;

      // A clear in the compare cycle still lets a fresh change through.
      if (state == CMP) begin
        snap_o <= accepted;
        chg_o  <= (irq_clr_i ? 32'h0 : chg_o) | diff;
      end else if (irq_clr_i) begin
        chg_o  <= 32'h0;
      end
    end
  end

endmodule

// File: doc/gpio_poll_master.md
GPIO_POLL_MASTER -- requirements
Module: gpio_poll_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the GPIO block base address (ctrl register at +0, data register at +4).
REQ-002 SHALL have parameter POLL_DIV, default 16'd1000, the number of clk cycles spent in WAIT between polls (legal range 1..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  polling enable.
REQ-006 SHALL have port ctrl_i  input  32  value written to the GPIO ctrl register on each enable.
REQ-007 SHALL have port mask_i  input  32  bits whose change sets the interrupt.
REQ-008 SHALL have port irq_clr_i  input  1  clears all sticky change bits.
REQ-009 SHALL have port req_o  output  1  bus request.
REQ-010 SHALL have port gnt_i  input  1  bus grant; a transfer completes in any cycle where req_o=1 and gnt_i=1.
REQ-011 SHALL have ports we_o  output  1, addr_o  output  32, data_o  output  32: write enable, address and write data.
REQ-012 SHALL have port data_i  input  32  read data, valid combinationally in the granted cycle.
REQ-013 SHALL have ports snap_o  output  32 (last accepted GPIO data), chg_o  output  32 (sticky changed bits) and irq_o  output  1 (equal to |chg_o).

Function
REQ-014 SHALL implement an FSM with states IDLE, CFG, WAIT, RD and CMP.
REQ-015 IDLE: req_o=0; goes to CFG when en_i=1.
REQ-016 CFG: req_o=1, we_o=1, addr_o=BASE_ADDR, data_o=ctrl_i; on grant goes to WAIT with the counter loaded to POLL_DIV-1 and the first-sample flag set.
REQ-017 WAIT: req_o=0; the counter decrements each cycle and the FSM goes to RD on the cycle the counter is 0, so WAIT lasts exactly POLL_DIV cycles.
REQ-018 RD: req_o=1, we_o=0, addr_o=BASE_ADDR+4; on grant, data_i is registered into the sample register and the FSM goes to CMP.
REQ-019 req_o SHALL stay asserted with stable we_o/addr_o/data_o until granted, with no timeout.
REQ-020 CMP (one cycle): diff=(sample^snap_o)&mask_i; snap_o<=sample; chg_o<=chg_o|diff; then go to WAIT with the counter reloaded.
REQ-021 On the first CMP after CFG, diff SHALL be forced to 0 and the first-sample flag cleared, so only snap_o loads.
REQ-022 Latency: read granted in cycle N -> snap_o/chg_o/irq_o updated and visible in cycle N+2.
REQ-023 When irq_clr_i=1, chg_o<=0; if a nonzero diff occurs in the same cycle, chg_o<=diff (the new change wins).
REQ-024 When en_i=0 in any state, the FSM SHALL return to IDLE next cycle with req_o deasserted (an ungranted request is abandones), keeping snap_o and chg_o.
REQ-025 A grant arriving in the same cycle en_i falls SHALL still complete that transfer; the FSM still goes to IDLE.
REQ-026 Outside CFG, we_o and data_o SHALL be 0; outside CFG/RD, addr_o SHALL be 0.

Reset
REQ-027 rstn=0 SHALL asynchronously force state IDLE and set counter, sample, snap_o, chg_o, irq_o, req_o, we_o, addr_o and data_o to 0, and clear the first-sample flag.
REQ-028 Reset mid-transfer SHALL drop req_o immediately, without waiting for a clock edge.

Configuration
REQ-029 With GPIO_POLL_DEBOUNCE_EN defined: keep the previous raw sample; a bit is accepted into snap_o/diff only when two consecutive reads agree on it; other bits keep the old snap_o value.
REQ-030 Without GPIO_POLL_DEBOUNCE_EN: every read is accepted directly, and no previous-raw register is built.

Verification
REQ-031 en_i=1, ctrl_i=32'h0000_0008, gnt_i=1 -> one write, we_o=1, addr_o=BASE+0, data_o=32'h8, then a read at BASE+4 after POLL_DIV cycles.
REQ-032 mask_i=32'h3, data_i 0x0 then 0x2 -> chg_o=32'h2 and irq_o=1 two cycles after the second grant; data_i=0x4 with mask 0x3 -> no irq.
REQ-033 gnt_i held 0 for 20 cycles during RD -> req_o and addr_o=BASE+4 stay stable; grant -> transfer completes.
REQ-034 irq_clr_i=1 in the CMP cycle with diff=32'h1 -> chg_o=32'h1; irq_clr_i=1 with diff=0 -> chg_o=0.
REQ-035 en_i dropped during WAIT and rstn pulsed during RD -> IDLE and req_o=0 (immediately for reset); re-enable -> a new CFG write.
REQ-036 With debounce: reads 0x0, 0x1, 0x0, 0x1, 0x1 -> only the fifth read sets chg_o=32'h1; without debounce, the second read sets it.
